// File: rtl/alu_request_scheduler.sv
// Round-robin scheduler that shares one multi-cycle 32-bit ALU between N_REQ requesters,
// holding operands stable for the ALU latency and returning a held, flow-controlled response.
module alu_request_scheduler #(
  parameter int N_REQ   = 2,
  parameter int ALU_LAT = 3,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0][2:0]  req_op,
  input  logic [N_REQ-1:0][31:0] req_a,
  input  logic [N_REQ-1:0][31:0] req_b,
  output logic [2:0]             alu_op,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_overflow,
  output logic                   rsp_error,
  output logic                   busy
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [31:0]       alu_a_q, alu_a_d;
  logic [31:0]       alu_b_q, alu_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_error_q, rsp_error_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand;
  logic              sel_illegal;

  // Priority starts one past the last winner and wraps, so every waiting requester is reached.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i + 1);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign sel_illegal = (req_op[grant_idx][1:0] == 2'b11);

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a value unassigned and infer a latch.
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_error_d  = rsp_error_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          rr_ptr_d = grant_idx;
          rsp_id_d = grant_idx;
          if (sel_illegal) begin
            // Rejected without touching the ALU registers, so the ALU output stays meaningful.
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_error_d  = 1'b1;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end else begin
            alu_op_d = req_op[grant_idx];
            alu_a_d  = req_a[grant_idx];
            alu_b_d  = req_b[grant_idx];
            cnt_d    = '0;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_ovf_d    = alu_overflow;
          rsp_error_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(N_REQ - 1);
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_error    = rsp_error_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Bench for alu_request_scheduler: a delayed ALU model drives the ALU inputs and a
// transaction-level model predicts grants, latencies and responses.
module tb_alu_request_scheduler;

  localparam int N   = 2;
  localparam int LAT = 3;
  localparam int IDW = $clog2(N);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][2:0]   req_op;
  logic [N-1:0][31:0]  req_a;
  logic [N-1:0][31:0]  req_b;
  logic [2:0]          alu_op;
  logic [31:0]         alu_a, alu_b, alu_result;
  logic                alu_zero, alu_overflow;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_zero, rsp_overflow, rsp_error, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_request_scheduler #(.N_REQ(N), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {zero, overflow, result}; unused codes give garbage like a real ALU would.
  function automatic logic [33:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (op)
      3'b000:  s = {1'b0, a & b};
      3'b001:  s = {1'b0, a | b};
      3'b010:  s = {1'b0, a} + {1'b0, b};
      3'b110:  s = {(a < b), a - b};
      3'b100:  s = {a[31], a << 1};
      3'b101:  s = {a[0], a >> 1};
      default: s = {1'b1, a ^ b ^ 32'h5a5a_0001};
    endcase
    return {(s[31:0] == 32'd0), s};
  endfunction

  // ALU model: result/overflow final 2 edges after an input change, zero after 3.
  logic [33:0] alu_f;
  logic [31:0] r1 = '0, r2 = '0;
  logic        o1 = 1'b0, o2 = 1'b0, z1 = 1'b0, z2 = 1'b0, z3 = 1'b0;
  always @(posedge clk) begin
    alu_f = alu_fn(alu_op, alu_a, alu_b);
    r1 <= alu_f[31:0]; o1 <= alu_f[32]; z1 <= alu_f[33];
    r2 <= r1; o2 <= o1; z2 <= z1; z3 <= z2;
  end
  assign alu_result   = r2;
  assign alu_overflow = o2;
  assign alu_zero     = z3;

  // Expected response {error, zero, overflow, result}.
  function automatic logic [34:0] ref_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'b011 || op == 3'b111) return {1'b1, 34'd0};
    return {1'b0, alu_fn(op, a, b)};
  endfunction

  int          m_ptr = N - 1;
  logic [2:0]  e_op = '0;
  logic [31:0] e_a = '0, e_b = '0;
  int          last_acc = 0;
  int          last_span = 0;

  function automatic int next_grant(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", {rsp_result, rsp_zero, rsp_overflow, rsp_error}, 0);
  endtask

  // One full transaction: present vmask, check the grant, follow the response through
  // hold cycles of back-pressure and the handshake. obs_g is the grant seen on req_ready.
  task automatic run_txn(input logic [N-1:0] vmask, input int hold, input bit keep,
                         input bit chained, output int obs_g);
    logic [34:0]  exp;
    logic [N-1:0] exp_rdy;
    int g, edges, exp_lat;
    req_valid = vmask;
    rsp_ready = (hold == 0);
    g = next_grant(vmask);
    @(negedge clk);
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    check("req_ready_grant", req_ready, exp_rdy);
    obs_g = -1;
    for (int k = 0; k < N; k++) if (req_ready[k]) obs_g = k;
    @(posedge clk); #1;
    if (chained) check("accept_spacing", cyc - last_acc, last_span);
    last_acc = cyc;
    m_ptr = g;
    exp = ref_rsp(req_op[g], req_a[g], req_b[g]);
    if (!exp[34]) begin
      e_op = req_op[g]; e_a = req_a[g]; e_b = req_b[g];
    end
    if (keep) req_valid[g] = 1'b0;
    else      req_valid = '0;
    exp_lat = exp[34] ? 0 : LAT + 1;
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      check("alu_hold_wait", {alu_op, alu_a, alu_b}, {e_op, e_a, e_b});
      @(posedge clk); #1;
      edges++;
    end
    check("rsp_latency", edges, exp_lat);
    check("rsp_id", rsp_id, g);
    check("rsp_result", rsp_result, exp[31:0]);
    check("rsp_flags", {rsp_error, rsp_zero, rsp_overflow}, exp[34:32]);
    check("alu_regs", {alu_op, alu_a, alu_b}, {e_op, e_a, e_b});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("rsp_hold", {rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_error, rsp_id},
            {1'b1, exp[31:0], exp[33], exp[32], exp[34], IDW'(g)});
      check("ready_hold", req_ready, 0);
      check("busy_hold", busy, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_done", {rsp_valid, busy}, 0);
    last_span = exp_lat + 2 + hold;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int order [4];
    rst_n = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 reset_checks();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed arithmetic from requester 0.
    req_op[0] = 3'b010; req_a[0] = 32'd5; req_b[0] = 32'd7;
    run_txn(2'b01, 0, 0, 0, g);
    req_op[0] = 3'b110; req_a[0] = 32'd9; req_b[0] = 32'd9;
    run_txn(2'b01, 0, 0, 0, g);
    req_op[0] = 3'b010; req_a[0] = 32'hffff_ffff; req_b[0] = 32'd1;
    run_txn(2'b01, 0, 0, 0, g);
    req_op[0] = 3'b100; req_a[0] = 32'h8000_0000; req_b[0] = 32'h1234;
    run_txn(2'b01, 0, 0, 0, g);

    // Illegal opcode from requester 1.
    req_op[1] = 3'b011; req_a[1] = 32'hdead_beef; req_b[1] = 32'h1;
    run_txn(2'b10, 0, 0, 0, g);
    check("illegal_grant", g, 1);

    // Back-pressure for 10 cycles while requester 1 waits.
    req_op[0] = 3'b001; req_a[0] = 32'h00f0; req_b[0] = 32'h0f00;
    req_op[1] = 3'b101; req_a[1] = 32'h0000_0003; req_b[1] = 32'd0;
    run_txn(2'b11, 10, 1, 0, g);
    run_txn(2'b10, 0, 0, 1, g);
    check("pending_grant", g, 1);

    // Reset two cycles into WAIT.
    req_op[0] = 3'b010; req_a[0] = 32'd100; req_b[0] = 32'd23;
    req_valid = 2'b01; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    check("busy_in_wait", busy, 1);
    rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) begin @(posedge clk); #1; end
    check("rsp_valid_in_reset", rsp_valid, 0);
    rst_n = 1'b1;
    m_ptr = N - 1; e_op = '0; e_a = '0; e_b = '0;

    // Two requesters held valid: grants alternate starting at 0, one op per LAT+3 cycles.
    req_op[0] = 3'b000; req_a[0] = 32'hff00_ff00; req_b[0] = 32'h0ff0_0ff0;
    req_op[1] = 3'b110; req_a[1] = 32'd3;         req_b[1] = 32'd5;
    for (int k = 0; k < 4; k++) begin
      run_txn(2'b11, 0, 1, (k > 0), g);
      order[k] = g;
    end
    for (int k = 0; k < 4; k++) check("rr_order", order[k], k % 2);

    // Randomized traffic including illegal codes and back-pressure.
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < N; r++) begin
        req_op[r] = 3'($urandom_range(0, 7));
        req_a[r]  = ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : $urandom;
        req_b[r]  = ($urandom_range(0, 3) == 0) ? req_a[r] : $urandom;
      end
      run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3), 0, (i > 0), g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
